demux1_n_stream: RTL and testbench

//  Counterpart of the 2:1 selector: routes one valid/ready input stream to one of N_OUT output

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_skid2.sv | 79 +++++++
 rtl/demux1_n_stream.sv | 75 +++++++
 tb/tb_demux1_n_stream.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1:N stream demux: select-width helper and skid occupancy codes.
package demux_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   // ceil(log2(n)), never less than 1 so a select port always exists
   function automatic int unsigned sel_width(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if (n > (32'd1 << i)) w = 32'(i + 1);
      end
      return w;
   endfunction

endpackage

// File: rtl/demux_skid2.sv
// Two-entry valid/ready skid buffer; head register drives the output, full flag is registered.
module demux_skid2
   import demux_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push,
   output logic              full,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   logic [1:0]        occ_q, occ_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;
   logic              full_q, full_d;
   logic              valid_q, valid_d;
   logic              pop;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         occ_q   <= OCC_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         full_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         occ_q   <= occ_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         full_q  <= full_d;
         valid_q <= valid_d;
      end
   end

   // Occupancy transitions; a simultaneous push and pop at one entry replaces the head.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      pop    = out_ready & (occ_q != OCC_EMPTY);
      case (occ_q)
         OCC_EMPTY: begin
            if (push) begin
               head_d = push_data;
               occ_d  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (push && pop) begin
               head_d = push_data;
            end else if (push) begin
               tail_d = push_data;
               occ_d  = OCC_TWO;
            end else if (pop) begin
               occ_d = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            if (pop) begin
               head_d = tail_q;
               occ_d  = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
      full_d  = (occ_d == OCC_TWO);
      valid_d = (occ_d != OCC_EMPTY);
   end

   assign full      = full_q;
   assign out_data  = head_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/demux1_n_stream.sv
// Routes one valid/ready stream to one of N_OUT skid-buffered outputs; illegal selects are dropped and counted.
module demux1_n_stream
   import demux_pkg::*;
#(
   parameter  int unsigned DATA_W = 8,
   parameter  int unsigned N_OUT  = 2,
   parameter  int unsigned CNT_W  = 16,
   localparam int unsigned SEL_W  = sel_width(N_OUT)
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ready,
   output logic                    err_sel,
   output logic [CNT_W-1:0]        drop_cnt
);

   logic [N_OUT-1:0] full;
   logic [N_OUT-1:0] push;
   logic             sel_legal;
   logic             accept;
   logic             err_q, err_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   // in_ready depends only on in_sel and registered full flags, never on out_ready
   always_comb begin
      sel_legal = (32'(in_sel) < N_OUT);
      in_ready  = 1'b1;
      push      = '0;
      for (int k = 0; k < int'(N_OUT); k++) begin
         if (in_sel == SEL_W'(k)) in_ready = ~full[k];
      end
      accept = in_valid & in_ready;
      for (int k = 0; k < int'(N_OUT); k++) begin
         push[k] = accept & (in_sel == SEL_W'(k));
      end
      err_d  = accept & ~sel_legal;
      drop_d = drop_q;
      if (err_d && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         err_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         err_q  <= err_d;
         drop_q <= drop_d;
      end
   end

   assign err_sel  = err_q;
   assign drop_cnt = drop_q;

   for (genvar k = 0; k < int'(N_OUT); k++) begin : g_ch
      demux_skid2 #(
         .DATA_W (DATA_W)
      ) u_skid (
         .sys_clk   (sys_clk),
         .sys_rst   (sys_rst),
         .push_data (in_data),
         .push      (push[k]),
         .full      (full[k]),
         .out_data  (out_data[k*DATA_W +: DATA_W]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k])
      );
   end

endmodule

// File: tb/tb_demux1_n_stream.sv
// Self-checking bench: per-channel queue model compared every cycle, plus directed literal checks.
module tb_demux1_n_stream;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned N_OUT  = 3;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned SEL_W  = 2;

   logic                    sys_clk;
   logic                    sys_rst;
   logic [DATA_W-1:0]       in_data;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic [N_OUT*DATA_W-1:0] out_data;
   logic [N_OUT-1:0]        out_valid;
   logic [N_OUT-1:0]        out_ready;
   logic                    err_sel;
   logic [CNT_W-1:0]        drop_cnt;

   demux1_n_stream #(
      .DATA_W (DATA_W),
      .N_OUT  (N_OUT),
      .CNT_W  (CNT_W)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_sel   (err_sel),
      .drop_cnt  (drop_cnt)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [DATA_W-1:0] ch_data(input int k);
      return out_data[k*DATA_W +: DATA_W];
   endfunction

   // Reference model: one FIFO per channel of capacity 2, a drop counter and an error flag
   logic [DATA_W-1:0] mq [N_OUT][$];
   logic              m_err;
   int                m_drop;

   always @(negedge sys_clk) begin
      int  s;
      bit  exp_ready;
      bit  acc;
      if (sys_rst) begin
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_data", 32'(out_data), 32'd0);
         check("rst_err_sel", 32'(err_sel), 32'd0);
         check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd1);
         for (int k = 0; k < int'(N_OUT); k++) mq[k].delete();
         m_err  = 1'b0;
         m_drop = 0;
      end else begin
         s         = int'(in_sel);
         exp_ready = (s >= int'(N_OUT)) ? 1'b1 : (mq[s].size() < 2);
         check("in_ready", 32'(in_ready), 32'(exp_ready));
         for (int k = 0; k < int'(N_OUT); k++) begin
            check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
            if (mq[k].size() != 0)
               check($sformatf("out_data[%0d]", k), 32'(ch_data(k)), 32'(mq[k][0]));
         end
         check("err_sel", 32'(err_sel), 32'(m_err));
         check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
         // advance to the state after the coming rising edge
         acc = in_valid & exp_ready;
         for (int k = 0; k < int'(N_OUT); k++)
            if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
         m_err = acc && (s >= int'(N_OUT));
         if (m_err && m_drop < (1 << CNT_W) - 1) m_drop++;
         if (acc && s < int'(N_OUT)) mq[s].push_back(in_data);
      end
   end

   task automatic cyc(input logic v, input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] d,
                      input logic [N_OUT-1:0] ordy);
      @(posedge sys_clk);
      #1;
      in_valid  = v;
      in_sel    = sel;
      in_data   = d;
      out_ready = ordy;
      #1;
   endtask

   initial begin
      int hi;
      sys_rst   = 1'b1;
      in_valid  = 1'b0;
      in_sel    = '0;
      in_data   = '0;
      out_ready = '0;
      repeat (2) @(posedge sys_clk);
      #1;
      check("init_in_ready", 32'(in_ready), 32'd1);
      sys_rst = 1'b0;

      // streaming to two channels with consumers ready
      cyc(1, 2'd0, 8'h11, 3'b111);
      check("s_ready0", 32'(in_ready), 32'd1);
      cyc(1, 2'd1, 8'h22, 3'b111);
      check("s_ready1", 32'(in_ready), 32'd1);
      check("s_ch0_11", {23'd0, out_valid[0], ch_data(0)}, {23'd0, 1'b1, 8'h11});
      cyc(1, 2'd0, 8'h33, 3'b111);
      check("s_ch1_22", {23'd0, out_valid[1], ch_data(1)}, {23'd0, 1'b1, 8'h22});
      check("s_ch0_gap", 32'(out_valid[0]), 32'd0);
      cyc(0, 2'd0, 8'h00, 3'b111);
      check("s_ch0_33", {23'd0, out_valid[0], ch_data(0)}, {23'd0, 1'b1, 8'h33});

      // backpressure on ch0, then isolation of ch1
      cyc(1, 2'd0, 8'hA0, 3'b110);
      check("b_ready_a0", 32'(in_ready), 32'd1);
      cyc(1, 2'd0, 8'hA1, 3'b110);
      check("b_ready_a1", 32'(in_ready), 32'd1);
      cyc(1, 2'd0, 8'hA2, 3'b110);
      check("b_ready_a2", 32'(in_ready), 32'd0);
      check("b_head_a0", 32'(ch_data(0)), 32'h A0);
      cyc(1, 2'd1, 8'h5A, 3'b110);
      check("i_ready_5a", 32'(in_ready), 32'd1);
      cyc(1, 2'd1, 8'h5B, 3'b110);
      check("i_ready_5b", 32'(in_ready), 32'd1);
      check("i_ch1_5a", {23'd0, out_valid[1], ch_data(1)}, {23'd0, 1'b1, 8'h5A});
      check("i_ch0_hold", 32'(ch_data(0)), 32'h A0);
      cyc(0, 2'd0, 8'h00, 3'b110);
      check("i_ch1_5b", {23'd0, out_valid[1], ch_data(1)}, {23'd0, 1'b1, 8'h5B});
      check("i_ch0_hold2", {23'd0, out_valid[0], ch_data(0)}, {23'd0, 1'b1, 8'hA0});
      cyc(1, 2'd0, 8'hA2, 3'b111);
      check("b_still_full", 32'(in_ready), 32'd0);
      cyc(1, 2'd0, 8'hA2, 3'b111);
      check("b_ready_back", 32'(in_ready), 32'd1);
      check("b_head_a1", 32'(ch_data(0)), 32'h A1);
      cyc(0, 2'd0, 8'h00, 3'b111);
      check("b_head_a2", {23'd0, out_valid[0], ch_data(0)}, {23'd0, 1'b1, 8'hA2});
      cyc(0, 2'd0, 8'h00, 3'b111);
      check("b_drained", 32'(out_valid), 32'd0);

      // illegal select and counter saturation
      cyc(1, 2'd3, 8'hFF, 3'b111);
      check("e_ready", 32'(in_ready), 32'd1);
      cyc(0, 2'd0, 8'h00, 3'b111);
      check("e_err_pulse", 32'(err_sel), 32'd1);
      check("e_drop1", 32'(drop_cnt), 32'd1);
      check("e_no_valid", 32'(out_valid), 32'd0);
      cyc(0, 2'd0, 8'h00, 3'b111);
      check("e_err_clear", 32'(err_sel), 32'd0);
      for (int i = 0; i < 20; i++) cyc(1, 2'd3, 8'(i), 3'b111);
      cyc(0, 2'd0, 8'h00, 3'b111);
      cyc(0, 2'd0, 8'h00, 3'b111);
      check("e_drop_sat", 32'(drop_cnt), 32'd15);
      check("e_err_end", 32'(err_sel), 32'd0);

      // reset with two words held in ch0
      cyc(1, 2'd0, 8'hB0, 3'b000);
      cyc(1, 2'd0, 8'hB1, 3'b000);
      cyc(0, 2'd0, 8'h00, 3'b000);
      check("r_full", 32'(in_ready), 32'd0);
      check("r_head_b0", {23'd0, out_valid[0], ch_data(0)}, {23'd0, 1'b1, 8'hB0});
      @(posedge sys_clk);
      #1;
      sys_rst  = 1'b1;
      in_valid = 1'b1;
      #1;
      check("r_valid", 32'(out_valid), 32'd0);
      check("r_drop", 32'(drop_cnt), 32'd0);
      check("r_ready", 32'(in_ready), 32'd1);
      @(posedge sys_clk);
      #1;
      sys_rst   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 3'b111;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 2'd0, 8'h00, 3'b111);
         check("r_no_stale", 32'(out_valid), 32'd0);
      end

      // randomized traffic with alternating light and heavy backpressure phases
      for (int i = 0; i < 10000; i++) begin
         logic [N_OUT-1:0] r;
         hi = ((i / 500) % 2 == 0) ? 9 : 3;
         for (int k = 0; k < int'(N_OUT); k++) r[k] = ($urandom_range(0, 9) < hi);
         cyc(($urandom_range(0, 9) < 7), SEL_W'($urandom_range(0, 3)), DATA_W'($urandom), r);
      end
      for (int i = 0; i < 4; i++) cyc(0, 2'd0, 8'h00, 3'b111);
      check("final_drained", 32'(out_valid), 32'd0);

      @(posedge sys_clk);
      #6;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
